// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for the 5-stage
// MIPS pipeline. Drives the active-low hold/flush controls of PC, IF/ID,
// ID/EX and EX/MEM. Handles load-use stalls, branch/jump flushes,
// data-memory waits with a watchdog, and interrupt entry.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ID_Rs, ID_Rt, ID_UseRt     source operands of the instruction in ID
//   ID_Jump                    jump in ID
//   EX_MemRd, EX_Rt            load in EX and its destination
//   EX_BranchTaken             taken branch resolved in EX
//   mem_busy                   data memory not ready
//   irq                        level interrupt request
//   *_stall                    active-low holds (0 = keep value)
//   *_clear                    active-low flushes (0 = load bubble)
//   irq_ack                    one-cycle interrupt-taken pulse
//   mem_timeout                sticky memory watchdog flag
//   state                      FSM state (debug)
//
// Optional build macro HAZARD_PERF_CNT_EN adds perf_stall_cnt,
// perf_flush_cnt and perf_memwait_cnt (32-bit saturating) output ports.

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRt,
    input  logic        ID_Jump,
    input  logic        EX_MemRd,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_BranchTaken,
    input  logic        mem_busy,
    input  logic        irq,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        ID_EX_stall,
    output logic        EX_MEM_stall,
    output logic        IF_ID_clear,
    output logic        ID_EX_clear,
    output logic        irq_ack,
    output logic        mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_IRQ1    = 2'd2,
        S_IRQ2    = 2'd3
    } state_t;

    localparam logic [15:0] LP_TO = 16'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_nxt;
    logic        r_irq_pend;
    logic        r_timeout;

    logic        w_lu;
    logic        w_freeze;
    logic        w_run;
    logic        w_lu_stall;
    logic        w_pc_stall;
    logic        w_ifid_stall;
    logic        w_idex_stall;
    logic        w_exmem_stall;
    logic        w_ifid_clear;
    logic        w_idex_clear;
    logic        w_ack;

    assign w_lu = EX_MemRd && (EX_Rt != 5'd0) &&
                  ((EX_Rt == ID_Rs) || (ID_UseRt && (EX_Rt == ID_Rt)));

    always_comb begin
        w_state_nxt   = r_state;
        w_freeze      = 1'b0;
        w_run         = 1'b0;
        w_lu_stall    = 1'b0;
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
        w_ifid_clear  = 1'b1;
        w_idex_clear  = 1'b1;
        w_ack         = 1'b0;

        unique case (r_state)
            S_RUN: begin
                if (mem_busy) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = S_MEMWAIT;
                end else begin
                    w_run = 1'b1;
                end
            end
            S_MEMWAIT: begin
                if (mem_busy) begin
                    w_freeze = 1'b1;
                end else begin
                    // Memory released: act on held hazards this same cycle.
                    w_run       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_IRQ1: begin
                if (mem_busy) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = S_MEMWAIT;
                end else begin
                    w_ifid_clear = 1'b0;
                    w_state_nxt  = S_IRQ2;
                end
            end
            S_IRQ2: begin
                w_ifid_clear = 1'b0;
                w_state_nxt  = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase

        if (w_freeze) begin
            w_pc_stall    = 1'b0;
            w_ifid_stall  = 1'b0;
            w_idex_stall  = 1'b0;
            w_exmem_stall = 1'b0;
        end

        if (w_run) begin
            if (EX_BranchTaken) begin
                w_ifid_clear = 1'b0;
                w_idex_clear = 1'b0;
            end else if (w_lu) begin
                w_lu_stall   = 1'b1;
                w_pc_stall   = 1'b0;
                w_ifid_stall = 1'b0;
                w_idex_clear = 1'b0;
            end else if (r_irq_pend) begin
                w_ack        = 1'b1;
                w_ifid_clear = 1'b0;
                w_idex_clear = 1'b0;
                w_state_nxt  = S_IRQ1;
            end else if (ID_Jump) begin
                w_ifid_clear = 1'b0;
            end
        end

        if (reset) begin
            w_state_nxt   = S_RUN;
            w_lu_stall    = 1'b0;
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_ifid_clear  = 1'b1;
            w_idex_clear  = 1'b1;
            w_ack         = 1'b0;
        end
    end

    // Wait counter: loaded with 1 on entry, saturates at the timeout.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (w_freeze) begin
            if (r_state != S_MEMWAIT) begin
                w_wait_cnt_nxt = 16'd1;
            end else if (r_wait_cnt < LP_TO) begin
                w_wait_cnt_nxt = r_wait_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 16'd0;
            r_irq_pend <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_irq_pend <= irq | (r_irq_pend & ~w_ack);
            if (w_freeze && (w_wait_cnt_nxt >= LP_TO)) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_memwait;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall   <= 32'd0;
            r_perf_flush   <= 32'd0;
            r_perf_memwait <= 32'd0;
        end else begin
            if (w_lu_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((!w_ifid_clear || !w_idex_clear) &&
                (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if ((r_state == S_MEMWAIT) && (r_perf_memwait != '1)) begin
                r_perf_memwait <= r_perf_memwait + 32'd1;
            end
        end
    end

    assign perf_stall_cnt   = r_perf_stall;
    assign perf_flush_cnt   = r_perf_flush;
    assign perf_memwait_cnt = r_perf_memwait;
`else
    logic w_unused;
    assign w_unused = w_lu_stall;
`endif

    assign PC_stall     = w_pc_stall;
    assign IF_ID_stall  = w_ifid_stall;
    assign ID_EX_stall  = w_idex_stall;
    assign EX_MEM_stall = w_exmem_stall;
    assign IF_ID_clear  = w_ifid_clear;
    assign ID_EX_clear  = w_idex_clear;
    assign irq_ack      = w_ack;
    assign mem_timeout  = r_timeout;
    assign state        = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for
// pipeline_hazard_ctrl (MEM_TIMEOUT = 4).

module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rt;
    logic       ID_UseRt, ID_Jump, EX_MemRd, EX_BranchTaken;
    logic       mem_busy, irq;
    logic       PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic       IF_ID_clear, ID_EX_clear, irq_ack, mem_timeout;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .ID_Jump(ID_Jump), .EX_MemRd(EX_MemRd), .EX_Rt(EX_Rt),
        .EX_BranchTaken(EX_BranchTaken), .mem_busy(mem_busy), .irq(irq),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
        .ID_EX_stall(ID_EX_stall), .EX_MEM_stall(EX_MEM_stall),
        .IF_ID_clear(IF_ID_clear), .ID_EX_clear(ID_EX_clear),
        .irq_ack(irq_ack), .mem_timeout(mem_timeout),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_memwait_cnt(perf_memwait_cnt),
`endif
        .state(state)
    );

    function automatic logic [9:0] mk(input logic [3:0] s,
                                      input logic [1:0] c,
                                      input logic a, input logic t,
                                      input logic [1:0] st);
        return {s, c, a, t, st};
    endfunction

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
        ID_UseRt = 1'b0; ID_Jump = 1'b0; EX_MemRd = 1'b0;
        EX_BranchTaken = 1'b0; mem_busy = 1'b0; irq = 1'b0;
    endtask

    // Push expectation, sample mid-cycle, compare, advance one cycle.
    task automatic step(input string tag, input logic [9:0] e);
        logic [9:0] obs;
        logic [9:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        obs = {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
               IF_ID_clear, ID_EX_clear, irq_ack, mem_timeout, state};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, want);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset", mk(4'hF, 2'b11, 0, 0, 0));
        reset = 1'b0;

        step("idle", mk(4'hF, 2'b11, 0, 0, 0));

        EX_MemRd = 1; EX_Rt = 8; ID_Rs = 8;
        step("lu", mk(4'b0011, 2'b10, 0, 0, 0));
        step("lu_next", mk(4'hF, 2'b11, 0, 0, 0));

        EX_MemRd = 1; EX_Rt = 8; ID_Rs = 8; EX_BranchTaken = 1;
        step("br_over_lu", mk(4'hF, 2'b00, 0, 0, 0));

        EX_MemRd = 1; EX_Rt = 0; ID_Rs = 0;
        step("rt_zero", mk(4'hF, 2'b11, 0, 0, 0));

        EX_MemRd = 1; EX_Rt = 5; ID_Rs = 3; ID_Rt = 5; ID_UseRt = 1;
        step("lu_rt", mk(4'b0011, 2'b10, 0, 0, 0));
        EX_MemRd = 1; EX_Rt = 5; ID_Rs = 3; ID_Rt = 5; ID_UseRt = 0;
        step("rt_unused", mk(4'hF, 2'b11, 0, 0, 0));

        ID_Jump = 1;
        step("jump", mk(4'hF, 2'b01, 0, 0, 0));
        ID_Jump = 1; EX_MemRd = 1; EX_Rt = 9; ID_Rs = 9;
        step("jump_lu", mk(4'b0011, 2'b10, 0, 0, 0));

        mem_busy = 1;
        step("mw0", mk(4'h0, 2'b11, 0, 0, 0));
        mem_busy = 1;
        step("mw1", mk(4'h0, 2'b11, 0, 0, 1));
        mem_busy = 1;
        step("mw2", mk(4'h0, 2'b11, 0, 0, 1));
        mem_busy = 1;
        step("mw3", mk(4'h0, 2'b11, 0, 0, 1));
        mem_busy = 1;
        step("mw4_timeout", mk(4'h0, 2'b11, 0, 1, 1));
        ID_Jump = 1;
        step("mw_release", mk(4'hF, 2'b01, 0, 1, 1));
        step("mw_run", mk(4'hF, 2'b11, 0, 1, 0));

        irq = 1;
        step("irq_in", mk(4'hF, 2'b11, 0, 1, 0));
        step("irq_ack", mk(4'hF, 2'b00, 1, 1, 0));
        step("irq1", mk(4'hF, 2'b01, 0, 1, 2));
        step("irq2", mk(4'hF, 2'b01, 0, 1, 3));
        step("irq_done", mk(4'hF, 2'b11, 0, 1, 0));

        irq = 1;
        step("irq_in_b", mk(4'hF, 2'b11, 0, 1, 0));
        EX_MemRd = 1; EX_Rt = 4; ID_Rs = 4;
        step("irq_lu", mk(4'b0011, 2'b10, 0, 1, 0));
        step("irq_ack_late", mk(4'hF, 2'b00, 1, 1, 0));
        step("irq1_b", mk(4'hF, 2'b01, 0, 1, 2));
        step("irq2_b", mk(4'hF, 2'b01, 0, 1, 3));
        step("irq_done_b", mk(4'hF, 2'b11, 0, 1, 0));

        mem_busy = 1;
        step("rst_mw0", mk(4'h0, 2'b11, 0, 1, 0));
        mem_busy = 1;
        step("rst_mw1", mk(4'h0, 2'b11, 0, 1, 1));
        reset = 1; mem_busy = 1;
        step("rst_hold", mk(4'hF, 2'b11, 0, 1, 1));
        reset = 1; mem_busy = 1;
        step("rst_done", mk(4'hF, 2'b11, 0, 0, 0));
        reset = 0;
        step("rst_idle", mk(4'hF, 2'b11, 0, 0, 0));

`ifdef HAZARD_PERF_CNT_EN
        reset = 1;
        step("perf_rst", mk(4'hF, 2'b11, 0, 0, 0));
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            EX_MemRd = 1; EX_Rt = 7; ID_Rs = 7;
            step("perf_lu", mk(4'b0011, 2'b10, 0, 0, 0));
            step("perf_gap", mk(4'hF, 2'b11, 0, 0, 0));
        end
        EX_BranchTaken = 1;
        step("perf_br", mk(4'hF, 2'b00, 0, 0, 0));
        @(negedge clk);
        checks++;
        assert (perf_stall_cnt === 32'd3) else begin
            errors++;
            $error("FAIL perf_stall observed %0d expected 3",
                   perf_stall_cnt);
        end
        checks++;
        assert (perf_flush_cnt === 32'd4) else begin
            errors++;
            $error("FAIL perf_flush observed %0d expected 4",
                   perf_flush_cnt);
        end
        checks++;
        assert (perf_memwait_cnt === 32'd0) else begin
            errors++;
            $error("FAIL perf_memwait observed %0d expected 0",
                   perf_memwait_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Each cycle it drives the active-low hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, taken-branch and jump flushes, multi-cycle data-memory waits with a watchdog, and interrupt entry. It sits beside the ID/EX register and owns every `stall`/`clear` input in the pipeline.

## Interface
- `MEM_TIMEOUT`, default 255: memory-wait cycles before the watchdog flag sets. Legal range 1..65535.
- `clk  in  1`: pipeline clock.
- `reset  in  1`: synchronous, active-high.
- `ID_Rs, ID_Rt  in  5 each`: source registers of the instruction in ID.
- `ID_UseRt  in  1`: instruction in ID reads Rt.
- `ID_Jump  in  1`: instruction in ID is j/jal/jr/jalr.
- `EX_MemRd  in  1`: instruction in EX is a load.
- `EX_Rt  in  5`: destination of the load in EX.
- `EX_BranchTaken  in  1`: branch in EX resolved taken.
- `mem_busy  in  1`: data memory is not ready this cycle.
- `irq  in  1`: level interrupt request.
- `PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1 each`: active-low hold; 0 means the register keeps its value.
- `IF_ID_clear, ID_EX_clear  out  1 each`: active-low flush; 0 means the register loads a bubble.
- `irq_ack  out  1`: one-cycle pulse when the interrupt is taken.
- `mem_timeout  out  1`: sticky watchdog flag.
- `state  out  2`: FSM state, for debug.

## Operation
- **States:** RUN=0, MEMWAIT=1, IRQ1=2, IRQ2=3.
- **Default outputs:** every stall and clear output is 1, and `irq_ack` is 0.
- **Load-use condition (`lu`):** `EX_MemRd` && `EX_Rt`≠0 && (`EX_Rt`==`ID_Rs` || (`ID_UseRt` && `EX_Rt`==`ID_Rt`)).
- **Pending interrupt:** `irq_pend` is set by `irq` and cleared when `irq_ack` fires.
- **RUN**, priorities from highest to lowest:
  1. `mem_busy`: drive all four stall outputs to 0, go to MEMWAIT, load the wait counter with 1.
  2. `EX_BranchTaken`: drive `IF_ID_clear`=0 and `ID_EX_clear`=0. This overrides `lu` and `ID_Jump`.
  3. `lu`: drive `PC_stall`=0, `IF_ID_stall`=0 and `ID_EX_clear`=0. A jump in ID waits and is not flushed this cycle.
  4. `irq_pend`: drive `irq_ack`=1, `IF_ID_clear`=0 and `ID_EX_clear`=0, then go to IRQ1.
  5. `ID_Jump`: drive `IF_ID_clear`=0.
- **MEMWAIT:**
  - While `mem_busy` is high: all four stall outputs are 0 and no clear is asserted.
  - The wait counter increments and saturates at `MEM_TIMEOUT`. When it reaches `MEM_TIMEOUT`, `mem_timeout` sets.
  - When `mem_busy` falls: outputs follow the RUN rules in that same cycle, with `mem_busy` treated as 0, and the FSM returns to RUN. Any event held during the freeze is acted on in this cycle.
- **IRQ1:** drive `IF_ID_clear`=0 to squash the fetch made before the vector redirect, then go to IRQ2. `mem_busy` takes precedence, as in RUN.
- **IRQ2:** drive `IF_ID_clear`=0, then go to RUN. A new `irq` during IRQ1 or IRQ2 only sets `irq_pend`.
- **`mem_timeout`:** cleared only by reset.

## Timing
- All stall and clear outputs are combinational (Mealy) on the current state and inputs, so they act in the same cycle as the hazard.
- **Load-use:** exactly one bubble. In the next cycle the ID/EX register holds a bubble, so `EX_MemRd`=0 and `lu` deasserts.
- **Taken branch:** two instructions are squashed.
- **Jump:** one instruction is squashed.
- **Interrupt:** `irq_ack` fires 1 cycle after `irq` is sampled, provided the pipeline is in RUN with no higher-priority event.
- **Reset:**
  - Takes effect at the next `clk` edge, including mid-MEMWAIT or mid-IRQ sequence.
  - Resets `state`=RUN, wait counter=0, `irq_pend`=0 and `mem_timeout`=0.
  - While `reset` is high, all stall and clear outputs are 1 and `irq_ack`=0.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined:** adds three 32-bit saturating counters, `perf_stall_cnt`, `perf_flush_cnt` and `perf_memwait_cnt`, as output ports.
  - `perf_stall_cnt` increments once per cycle in which `lu` stalls.
  - `perf_flush_cnt` increments once per cycle in which any clear output is 0.
  - `perf_memwait_cnt` increments once per MEMWAIT cycle.
  - All three reset to 0.
- **Not defined:** the counters and their ports are absent, and behaviour is otherwise identical.

## Test plan
- **Load-use:** `EX_MemRd`=1, `EX_Rt`=8, `ID_Rs`=8 → `PC_stall`=`IF_ID_stall`=`ID_EX_clear`=0 for 1 cycle. The next cycle, with `EX_MemRd`=0, all outputs are 1.
- **Branch beats load-use:** `lu` true and `EX_BranchTaken`=1 in the same cycle → `IF_ID_clear`=`ID_EX_clear`=0, `PC_stall`=1. A load with `EX_Rt`=0 matching `ID_Rs`=0 produces no stall.
- **Memory wait:** `mem_busy` high for 5 cycles → all stalls are 0 for 5 cycles and `state`=1. With `MEM_TIMEOUT`=4, `mem_timeout` rises in the 4th MEMWAIT cycle and stays high after `mem_busy` falls.
- **Interrupt:** `irq` pulsed in RUN with no hazards → `irq_ack`=1 with `IF_ID_clear`=`ID_EX_clear`=0, then 2 further cycles of `IF_ID_clear`=0, then `state`=0. With `lu` true at the same time, `irq_ack` is delayed by one cycle.
- **Reset mid-operation:** `reset` asserted in MEMWAIT with `mem_busy`=1 → at the next edge `state`=0, `mem_timeout`=0 and all outputs are 1 while `reset` is high.
- **Counters (`HAZARD_PERF_CNT_EN`):** 3 load-use stalls plus 1 taken branch → `perf_stall_cnt`=3, `perf_flush_cnt`=4.
